// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK stimulus source and the demodulator tests:
// build defaults, source-mode encoding, PRBS7 constants and a saturating negate.
package bpsk_pkg;

    localparam int FIXDT_64_A_WIDTH           = 16;
    localparam int CARRIER_SAMPLES_PER_PERIOD = 16;
    localparam int SAMPLING_FREQ              = 1_000_000;
    localparam int CARRIER_FREQ               = 250_000;
    localparam int SAMPLES_PER_SYMBOL         = 8;

    typedef enum logic [1:0] {
        SRC_ALT   = 2'd0,
        SRC_PRBS7 = 2'd1,
        SRC_EXT   = 2'd2,
        SRC_ONE   = 2'd3
    } bpsk_src_mode_e;

    // x^7 + x^6 + 1: feedback is the XOR of the two top bits.
    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS = 7'h60;

    // Two's-complement negate of a w-bit value held sign-extended in x;
    // the most-negative value maps to the most-positive instead of itself.
    function automatic longint sat_neg(input longint x, input int w);
        longint lo;
        lo = -(64'sd1 <<< (w - 1));
        if (x == lo) begin
            return -lo - 64'sd1;
        end
        return -x;
    endfunction

endpackage

// File: rtl/bpsk_bit_source.sv
// Chooses the bit that keys the carrier: alternating, PRBS7, constant one or
// an external stream. Owns the current bit, LFSR and sticky underrun flag.
module bpsk_bit_source
    import bpsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       boundary,
    input  logic [1:0] mode,
    input  logic       ext_bit,
    input  logic       ext_valid,
    output logic       ext_ready,
    output logic       next_bit,
    output logic       underrun
);

    // Handshake: ext_ready is combinational and high only in a boundary cycle
    // in EXT mode outside reset; ext_bit is taken iff ext_ready && ext_valid.
    // ext_valid low in that cycle repeats the current bit and flags underrun.
    bpsk_src_mode_e src_mode;
    logic           cur_bit;
    logic [6:0]     lfsr;
    logic           lfsr_fb;
    logic           starve;

    assign src_mode = bpsk_src_mode_e'(mode);
    assign lfsr_fb  = ^(lfsr & PRBS7_TAPS);

    always_comb begin
        next_bit  = cur_bit;
        ext_ready = 1'b0;
        starve    = 1'b0;
        if (boundary) begin
            unique case (src_mode)
                SRC_ALT:   next_bit = ~cur_bit;
                SRC_PRBS7: next_bit = lfsr[6];
                SRC_EXT: begin
                    ext_ready = ~rst;
                    if (ext_valid) begin
                        next_bit = ext_bit;
                    end else begin
                        starve = 1'b1;
                    end
                end
                SRC_ONE:   next_bit = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_bit  <= 1'b0;
            lfsr     <= PRBS7_SEED;
            underrun <= 1'b0;
        end else begin
            if (boundary) begin
                cur_bit <= next_bit;
            end
            if (boundary && src_mode == SRC_PRBS7) begin
                lfsr <= {lfsr[5:0], lfsr_fb};
            end
            if (starve) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cosine_lut.sv
// Full-period cosine ROM with combinational read ports. The entry at pi is
// negative full scale, so a negated sample can reach the saturation case.
module cosine_lut #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 16,
    parameter int READ_PORTS = 1
) (
    input  logic [READ_PORTS*$clog2(DEPTH)-1:0] addr,
    output logic [READ_PORTS*WIDTH-1:0]         data
);

    localparam int AW = $clog2(DEPTH);

    function automatic longint cos_entry(input int k);
        longint amp;
        longint pi_q;
        longint x;
        longint x2;
        longint t;
        longint sum;
        int     q;
        bit     neg;
        amp = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
        if (k == 0) return amp;
        if (k == DEPTH / 2) return -amp - 64'sd1;
        if (k == DEPTH / 4 || k == 3 * DEPTH / 4) return 64'sd0;
        if (k < DEPTH / 4) begin
            q = k;
            neg = 1'b0;
        end else if (k < DEPTH / 2) begin
            q = DEPTH / 2 - k;
            neg = 1'b1;
        end else if (k < 3 * DEPTH / 4) begin
            q = k - DEPTH / 2;
            neg = 1'b1;
        end else begin
            q = DEPTH - k;
            neg = 1'b0;
        end
        // Q30 Taylor series on the first-quadrant angle.
        pi_q = 64'sd3373259426;
        x    = (pi_q * 64'sd2 * longint'(q)) / longint'(DEPTH);
        x2   = (x * x) >>> 30;
        sum  = 64'sd1 <<< 30;
        t    = sum;
        for (int n = 1; n <= 6; n++) begin
            t   = -((t * x2) >>> 30) / longint'((2 * n - 1) * (2 * n));
            sum = sum + t;
        end
        t = (sum * amp + (64'sd1 <<< 29)) >>> 30;
        return neg ? -t : t;
    endfunction

    logic [WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [WIDTH-1:0] ENTRY = WIDTH'(cos_entry(i));
        assign rom[i] = ENTRY;
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        assign data[p*WIDTH +: WIDTH] = rom[addr[p*AW +: AW]];
    end

endmodule

// File: rtl/bpsk_stimulus_gen.sv
// BPSK sample source: phase accumulator into a cosine ROM, keyed by a selectable
// bit stream, with a one-cycle registered output and a symbol-start strobe.
module bpsk_stimulus_gen
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_W     = FIXDT_64_A_WIDTH,
    parameter int LUT_DEPTH    = CARRIER_SAMPLES_PER_PERIOD,
    parameter int PHASE_STEP   = CARRIER_SAMPLES_PER_PERIOD / (SAMPLING_FREQ / CARRIER_FREQ),
    parameter int SPS          = SAMPLES_PER_SYMBOL,
    parameter int PHASE_OFFSET = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                ext_bit,
    input  logic                ext_valid,
    output logic                ext_ready,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                bit_out,
    output logic                sym_start,
    output logic                underrun
);

    localparam int AW = $clog2(LUT_DEPTH);
    localparam int CW = $clog2(SPS);

    logic [AW-1:0]              angle;
    logic [CW-1:0]              sym_cnt;
    logic                       boundary;
    logic                       next_bit;
    logic [SAMPLE_W-1:0]        lut_data;
    logic signed [SAMPLE_W-1:0] c;
    logic signed [SAMPLE_W-1:0] keyed;

    assign boundary = en && (sym_cnt == '0);

    bpsk_bit_source u_bit_source (
        .clk       (clk),
        .rst       (rst),
        .boundary  (boundary),
        .mode      (mode),
        .ext_bit   (ext_bit),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .next_bit  (next_bit),
        .underrun  (underrun)
    );

    cosine_lut #(
        .DEPTH      (LUT_DEPTH),
        .WIDTH      (SAMPLE_W),
        .READ_PORTS (1)
    ) u_lut (
        .addr (angle),
        .data (lut_data)
    );

    // The ROM is read with the pre-increment angle so the first sample after
    // reset sits exactly at PHASE_OFFSET.
    assign c     = signed'(lut_data);
    assign keyed = next_bit ? c : SAMPLE_W'(sat_neg(longint'(c), SAMPLE_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            angle        <= AW'(PHASE_OFFSET);
            sym_cnt      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            bit_out      <= 1'b0;
            sym_start    <= 1'b0;
        end else if (en) begin
            angle        <= angle + AW'(PHASE_STEP);
            sym_cnt      <= (sym_cnt == CW'(SPS - 1)) ? '0 : sym_cnt + CW'(1);
            sample_out   <= keyed;
            sample_valid <= 1'b1;
            bit_out      <= next_bit;
            sym_start    <= boundary;
        end else begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bpsk_stimulus_gen.sv
// Directed bench for bpsk_stimulus_gen: a driver pushes expected samples into a
// queue, a negedge monitor pops and compares every valid output.
module tb_bpsk_stimulus_gen;

    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int STEP  = 4;
    localparam int SPS   = 8;
    localparam int OFFS  = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         ext_bit;
    logic         ext_valid;
    logic         ext_ready;
    logic [W-1:0] sample_out;
    logic         sample_valid;
    logic         bit_out;
    logic         sym_start;
    logic         underrun;

    always #5 clk = ~clk;

    bpsk_stimulus_gen #(
        .SAMPLE_W     (W),
        .LUT_DEPTH    (DEPTH),
        .PHASE_STEP   (STEP),
        .SPS          (SPS),
        .PHASE_OFFSET (OFFS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .ext_bit      (ext_bit),
        .ext_valid    (ext_valid),
        .ext_ready    (ext_ready),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .bit_out      (bit_out),
        .sym_start    (sym_start),
        .underrun     (underrun)
    );

    logic [W+1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    int           m_angle;
    int           m_cnt;
    logic         m_bit;
    logic [6:0]   m_lfsr;
    logic         m_under;
    logic [W-1:0] last_sample;
    logic         last_bit;
    logic         log_prbs = 1'b0;
    logic         prbs_bits[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Hand-tabulated entries reachable with step 4 on a 16-entry ROM.
    function automatic logic [W-1:0] keyed_ref(input int a, input logic b);
        logic [W-1:0] c;
        case (a)
            0:       c = 16'h7FFF;
            4:       c = 16'h0000;
            8:       c = 16'h8000;
            12:      c = 16'h0000;
            default: c = 16'hDEAD;
        endcase
        if (b) return c;
        if (c == 16'h8000) return 16'h7FFF;
        return -c;
    endfunction

    task automatic model_reset();
        m_angle     = OFFS;
        m_cnt       = 0;
        m_bit       = 1'b0;
        m_lfsr      = 7'h7F;
        m_under     = 1'b0;
        last_sample = '0;
        last_bit    = 1'b0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic e, input logic [1:0] md, input logic eb, input logic ev);
        logic bnd;
        logic nb;
        en        = e;
        mode      = md;
        ext_bit   = eb;
        ext_valid = ev;
        #1;
        bnd = e && (m_cnt == 0);
        check("ext_ready", 64'(ext_ready), 64'(bnd && md == 2'd2));
        if (e) begin
            nb = m_bit;
            if (bnd) begin
                case (md)
                    2'd0: nb = ~m_bit;
                    2'd1: begin
                        nb     = m_lfsr[6];
                        m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
                    end
                    2'd2: begin
                        if (ev) nb = eb;
                        else m_under = 1'b1;
                    end
                    default: nb = 1'b1;
                endcase
            end
            m_bit = nb;
            exp_q.push_back({nb, bnd, keyed_ref(m_angle, nb)});
            m_angle = (m_angle + STEP) % DEPTH;
            m_cnt   = (m_cnt + 1) % SPS;
        end
        @(posedge clk);
        #1;
        check("underrun", 64'(underrun), 64'(m_under));
        if (!e) begin
            check("stall_valid", 64'(sample_valid), 64'd0);
            check("stall_hold_sample", 64'(sample_out), 64'(last_sample));
            check("stall_hold_bit", 64'(bit_out), 64'(last_bit));
        end
    endtask

    // Reset asserted with a handshake offered and en high: reset must win.
    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b1;
        mode      = 2'd2;
        ext_bit   = 1'b1;
        ext_valid = 1'b1;
        #1;
        check("rst_ext_ready", 64'(ext_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst_sample_out", 64'(sample_out), 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_bit_out", 64'(bit_out), 64'd0);
        check("rst_sym_start", 64'(sym_start), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        rst = 1'b0;
        en  = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got 0x%0h, expected no output at %0t", sample_out, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sample", 64'({bit_out, sym_start, sample_out}), 64'(e));
                    last_sample = sample_out;
                    last_bit    = bit_out;
                    if (log_prbs && sym_start) prbs_bits.push_back(bit_out);
                end
            end
        end
    end

    initial begin : driver
        logic       bits4 [4];
        int         period_err;
        rst       = 1'b1;
        en        = 1'b0;
        mode      = 2'd0;
        ext_bit   = 1'b0;
        ext_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Alternating bits, carrier at angles 0,4,8,12 including the saturating negate.
        do_reset();
        repeat (32) step(1'b1, 2'd0, 1'b0, 1'b0);

        // PRBS7 over 1000 symbols.
        do_reset();
        log_prbs = 1'b1;
        repeat (8000) step(1'b1, 2'd1, 1'b0, 1'b0);
        do_reset();
        log_prbs = 1'b0;
        check("prbs_count", 64'(prbs_bits.size()), 64'd1000);
        if (prbs_bits.size() >= 8) begin
            check("prbs_first7", 64'({prbs_bits[0], prbs_bits[1], prbs_bits[2], prbs_bits[3],
                                      prbs_bits[4], prbs_bits[5], prbs_bits[6]}), 64'h7F);
            check("prbs_eighth", 64'(prbs_bits[7]), 64'd0);
        end
        period_err = 0;
        for (int i = 0; i + 127 < prbs_bits.size(); i++) begin
            if (prbs_bits[i] !== prbs_bits[i + 127]) period_err++;
        end
        check("prbs_period127", 64'(period_err), 64'd0);

        // External stream 1,1,0,1, then a starved boundary and a sticky flag.
        bits4 = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int b = 0; b < 4; b++) begin
            repeat (SPS) step(1'b1, 2'd2, bits4[b], 1'b1);
        end
        repeat (SPS) step(1'b1, 2'd2, 1'b0, 1'b0);
        repeat (SPS) step(1'b1, 2'd0, 1'b0, 1'b0);
        do_reset();

        // Three-cycle stall mid-symbol, then a mode change that waits for the boundary.
        repeat (3) step(1'b1, 2'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 2'd0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 2'd3, 1'b0, 1'b0);
        repeat (16) step(1'b1, 2'd3, 1'b0, 1'b0);

        // Reset at sym_cnt 5, then a fresh first symbol.
        do_reset();
        repeat (SPS + 5) step(1'b1, 2'd0, 1'b0, 1'b0);
        do_reset();
        repeat (SPS + 2) step(1'b1, 2'd0, 1'b0, 1'b0);

        en = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bpsk_stimulus_gen.md
# bpsk_stimulus_gen

Synthesizable, parametrised BPSK sample source that replaces ad-hoc testbench stimulus for `bpsk_demodulator_top`. It runs a phase accumulator into `cosine_lut`, keys the carrier with a bit stream, and emits signed carrier samples. The bit stream can be alternating, PRBS7, constant-one, or external via a valid/ready handshake. It also outputs the transmitted bit and a symbol strobe so a checker can compare against the demodulator output. It can also drive the demodulator on hardware for loopback tests.

## Interface
- `SAMPLE_W`, default `FIXDT_64_A_WIDTH`: sample width, signed.
- `LUT_DEPTH`, default `CARRIER_SAMPLES_PER_PERIOD`: LUT entries per carrier period. Must be a power of 2.
- `PHASE_STEP`, default `CARRIER_SAMPLES_PER_PERIOD/(SAMPLING_FREQ/CARRIER_FREQ)`: angle increment per sample.
- `SPS`, default `SAMPLES_PER_SYMBOL`: samples per symbol, at least 2.
- `PHASE_OFFSET`, default 0: angle loaded at reset.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: advance one sample per cycle while high.
- `mode` in 2: 0 alternate, 1 PRBS7, 2 external, 3 constant one.
- `ext_bit` in 1: external data bit.
- `ext_valid` in 1: `ext_bit` is valid.
- `ext_ready` out 1: block consumes `ext_bit` in this cycle.
- `sample_out` out `SAMPLE_W`: modulated sample, signed.
- `sample_valid` out 1: `sample_out`, `bit_out` and `sym_start` are valid.
- `bit_out` out 1: bit that keys `sample_out`.
- `sym_start` out 1: `sample_out` is the first sample of a symbol.
- `underrun` out 1: sticky flag; set when external mode had no data at a symbol boundary.

## Operation
- **State.** `angle` is `$clog2(LUT_DEPTH)` bits. `sym_cnt` counts 0..`SPS`-1. `cur_bit`, a 7-bit `lfsr`, and the `underrun` flag complete the state.
- **Reset values.**
  - `angle` = `PHASE_OFFSET`; `sym_cnt` = 0; `cur_bit` = 0; `lfsr` = 7'h7F.
  - All outputs are 0.
- **Enabled cycle** (`en` = 1):
  - `angle` += `PHASE_STEP`, wrapping mod `LUT_DEPTH`.
  - `sym_cnt` increments and wraps from `SPS`-1 to 0.
- **Boundary cycle.** A boundary cycle is an enabled cycle with `sym_cnt` = 0. In it, `next_bit` is selected from `mode`, sampled only in that cycle:
  - Mode 0: `next_bit` = ~`cur_bit`.
  - Mode 1: `next_bit` = `lfsr[6]`, then `lfsr` <= {`lfsr[5:0]`, `lfsr[6]^lfsr[5]`} (polynomial x^7+x^6+1).
  - Mode 2: `next_bit` = `ext_bit` if `ext_valid`. Otherwise `next_bit` = `cur_bit`, and `underrun` is set.
  - Mode 3: `next_bit` = 1.
  - `cur_bit` <= `next_bit`.
- **Non-boundary cycles.** `next_bit` = `cur_bit`.
- **Handshake.** `ext_ready` = `en` & (`sym_cnt` = 0) & (`mode` = 2), combinational. A transfer happens when `ext_ready` and `ext_valid` are both high. `ext_bit` is not consumed in any other cycle.
- **Keying.**
  - `c` = `cosine_lut`(`angle`), using the current angle, before the increment.
  - Sample = `c` if `next_bit` = 1, otherwise -`c`.
  - Negating the most-negative value saturates to the most-positive value.
- **Mode changes.** A `mode` change mid-symbol takes effect at the next boundary. The current symbol is never truncated.
- **`en` low.** All state freezes, `sample_valid` = 0, and `sample_out`/`bit_out` hold their values. A stall mid-symbol does not change symbol length in enabled samples.
- **Underrun.** The flag is cleared only by `rst`.

## Timing
- Latency is one cycle. An enabled cycle at edge k produces `sample_out`, `bit_out` and `sym_start` registered at edge k+1, with `sample_valid` = 1.
- `sym_start` = 1 exactly on samples from boundary cycles, i.e. one sample in every `SPS` enabled samples.
- **First sample after reset** (first enabled cycle after `rst` falls):
  - `angle` = `PHASE_OFFSET` and it is a boundary.
  - Mode 0 gives first bit 1; mode 1 gives first bit 1.
- **`rst` mid-symbol.** Reset wins over `en` and over a pending handshake: `ext_ready` is forced to 0 during `rst`, and all state returns to reset values at the next edge.
- **Throughput.** One sample per enabled cycle, with no bubbles.

## Structure
- **Shared package** (`bpsk_pkg`, `import`ed; `params.svh` is still `include`d for the defaults):
  - mode enum `bpsk_src_mode_e` (ALT, PRBS7, EXT, ONE);
  - PRBS7 seed and taps;
  - a saturating-negate function, reused by the demodulator tests.
- **Sub-modules.**
  - Instantiate the existing `cosine_lut` with `READ_PORTS` = 1.
  - New sub-module `bpsk_bit_source`: owns `cur_bit`, `lfsr`, mode select, handshake and `underrun`. Its inputs are `boundary`/`mode`/`ext_*`; it returns `next_bit`.
  - The top holds `angle`, `sym_cnt`, keying and output registers.

## Test plan
All scenarios use `LUT_DEPTH` = 16, `PHASE_STEP` = 4, `SPS` = 8, unless stated.
1. **Mode 0, `en` held high.**
   - Angles run 0,4,8,12,0…
   - `sym_start` pulses every 8 valid samples.
   - `bit_out` runs 1,0,1,0…
   - `sample_out` equals ±LUT[0,4,8,12] with the sign matching `bit_out`.
2. **Mode 1.**
   - The first 7 symbol bits are 1, the 8th is 0.
   - The sequence repeats after 127 symbols.
   - The bitwise XOR of the bit stream with a reference LFSR model is all-zero over 1000 symbols.
3. **Mode 2 with `ext_valid` held high.**
   - `ext_ready` pulses only on boundary cycles.
   - Bits 1,1,0,1 appear on `bit_out` in order.
   - With `ext_valid` then dropped at a boundary: the previous bit repeats, `underrun` goes to 1 and stays 1 until `rst`.
4. **Toggle `en` low for 3 cycles mid-symbol.**
   - `sample_valid` = 0 during the stall and the outputs hold.
   - The symbol still contains exactly 8 valid samples.
   - `mode` switched 0→3 mid-symbol takes effect at the next `sym_start`.
5. **Assert `rst` for 1 cycle at `sym_cnt` = 5.**
   - At the next edge all outputs are 0.
   - The first post-reset sample has `angle` = `PHASE_OFFSET`, `sym_start` = 1, `bit_out` = 1.
   - Saturation check: a LUT entry forced to -2^(`SAMPLE_W`-1) with `bit_out` = 0 yields 2^(`SAMPLE_W`-1)-1.
